// File: rtl/bluetooth_tx_packetizer.sv
// Point FIFO plus byte framer feeding bluetooth_tx over the send_data/finished_sending handshake.
// Define PACKETIZER_CHECKSUM_EN to append an XOR checksum byte (5-byte packets instead of 4).
module bluetooth_tx_packetizer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic                          point_valid,
    output logic                          point_ready,
    input  logic [8:0]                    point_x,
    input  logic [7:0]                    point_y,
    input  logic [2:0]                    point_color,
    input  logic                          point_pen,
    output logic [7:0]                    tx_data,
    output logic                          send_data,
    input  logic                          finished_sending,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   packets_sent
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};
`ifdef PACKETIZER_CHECKSUM_EN
    localparam logic [2:0] LastIdx = 3'd4;
`else
    localparam logic [2:0] LastIdx = 3'd3;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StNext} state_e;

    logic [20:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, push, pop;

    state_e      state_q;
    logic [20:0] pkt_q;
    logic [2:0]  idx_q;
    logic [7:0]  tx_data_q;
    logic        send_data_q;
    logic [15:0] packets_sent_q;

    // Entry layout: {pen, color[2:0], x[8:0], y[7:0]}
    function automatic logic [7:0] pkt_byte(input logic [20:0] pkt, input logic [2:0] idx);
        logic [7:0] b1, b2, b3, res;
        b1 = pkt[15:8];
        b2 = pkt[7:0];
        b3 = {pkt[20:17], 3'b000, pkt[16]};
        case (idx)
            3'd1:    res = b1;
            3'd2:    res = b2;
            3'd3:    res = b3;
`ifdef PACKETIZER_CHECKSUM_EN
            3'd4:    res = b1 ^ b2 ^ b3;
`endif
            default: res = SYNC_BYTE;
        endcase
        return res;
    endfunction

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign point_ready = !rst_in && !full;
    assign push        = point_valid && point_ready;
    // LOAD is only entered with a non-empty FIFO, so the pop never underflows.
    assign pop         = (state_q == StLoad);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {point_pen, point_color, point_x, point_y};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q        <= StIdle;
            pkt_q          <= '0;
            idx_q          <= '0;
            tx_data_q      <= '0;
            send_data_q    <= 1'b0;
            packets_sent_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) state_q <= StLoad;
                end
                StLoad: begin
                    pkt_q       <= mem_q[rd_ptr_q[AW-1:0]];
                    idx_q       <= '0;
                    tx_data_q   <= SYNC_BYTE;
                    send_data_q <= 1'b1;
                    state_q     <= StSend;
                end
                StSend: begin
                    if (finished_sending) begin
                        if (idx_q == LastIdx) begin
                            packets_sent_q <= packets_sent_q + 16'd1;
                            send_data_q    <= 1'b0;
                            state_q        <= StNext;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            tx_data_q <= pkt_byte(pkt_q, idx_q + 3'd1);
                        end
                    end
                end
                StNext: begin
                    state_q <= empty ? StIdle : StLoad;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_data      = tx_data_q;
    assign send_data    = send_data_q;
    assign packets_sent = packets_sent_q;
    assign fifo_count   = wr_ptr_q - rd_ptr_q;
    assign busy         = (state_q != StIdle) || !empty;

endmodule
